regbank_wb: RTL
===============

Name: regbank_wb

Overview:
- Write-side front end of the 16x16 register bank. It is the single producer of the bank's We/Addr_Rd/W_Data.
- Merges two result sources into the one bank write port:
  - a single-cycle ALU path that cannot be back-pressured;
  - a multi-cycle memory/slow-unit path with valid/ready handshake, buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on RAW/WAW hazards.

Parameters:
- DEPTH, 4: memory-result FIFO entries. Power of two, at least 2.
- STARVE_MAX, 3: consecutive cycles a non-empty FIFO may lose arbitration before Wb_Stall asserts. At least 1.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Alu_Valid  in  1  ALU result present this cycle.
- Alu_Rd  in  4  ALU destination register.
- Alu_Data  in  16  ALU result.
- Mem_Valid  in  1  memory result offered.
- Mem_Rd  in  4  memory destination register.
- Mem_Data  in  16  memory result.
- Mem_Ready  out  1  FIFO can accept; transfer occurs when Mem_Valid && Mem_Ready.
- Iss_Valid  in  1  decode issues an instruction that writes Iss_Rd.
- Iss_Rd  in  4  destination being issued.
- Qry_Ra  in  4  hazard query address.
- Qry_Rb  in  4  hazard query address.
- Qry_Rd  in  4  hazard query address.
- Hazard  out  1  combinational: any queried register is busy.
- Wb_Stall  out  1  registered: decode must hold Alu_Valid low in this cycle.
- We  out  1  registered bank write enable.
- Addr_Rd  out  4  registered bank write address.
- W_Data  out  16  registered bank write data.
- Busy  out  16  scoreboard vector. Bit 0 is constant 0.
- Err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (Rst_n low, asynchronous): We=0, Addr_Rd=0, W_Data=0, Busy=0, Wb_Stall=0, Err=0, FIFO empty, starvation counter 0.
- Mem_Ready = !full, combinational. It is 1 during and immediately after reset.
- Arbitration, evaluated every cycle:
  1. If Alu_Valid: the ALU wins. Register {Alu_Rd, Alu_Data} to the outputs.
  2. Otherwise, if the FIFO is not empty: pop the head and register it.
  3. Otherwise: We=0 next cycle. Addr_Rd and W_Data hold their previous values.
- Latency: a result accepted in cycle N appears on We/Addr_Rd/W_Data in cycle N+1. The bank captures it at the end of N+1.
  - ALU: N is the cycle Alu_Valid is high.
  - Memory: N is the pop cycle. The minimum is push cycle +1 (the FIFO is not fall-through).
- Destination r0: the winner is consumed (a FIFO entry is still popped) but We stays 0 for it.
- FIFO push (Mem_Valid && Mem_Ready) and pop in the same cycle are both allowed. Count is unchanged.
  - When full, no push is accepted, even if a pop occurs that cycle.
  - Wrap-around: pointers are log2(DEPTH)+1 bits.
- Scoreboard:
  - Iss_Valid && Iss_Rd!=0 sets Busy[Iss_Rd] at the clock edge.
  - A committed write (We=1 at an edge) clears Busy[Addr_Rd] at that same edge. Data is therefore in the bank when Busy drops.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard = Busy[Qry_Ra] | Busy[Qry_Rb] | Busy[Qry_Rd]. Address 0 never hazards.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and the ALU wins. It resets to 0 on any FIFO pop or when the FIFO is empty.
  - Wb_Stall is registered high for the cycle after the counter reaches STARVE_MAX-1.
  - If Alu_Valid is high while Wb_Stall is high: the ALU still wins and Err sets sticky.
- Protocol violations that set Err sticky (behaviour otherwise proceeds as written):
  - Iss_Valid to a register that is already busy.
  - A result (ALU or pushed memory) whose destination is a non-zero register that is not busy.
- Err clears only on reset.
- Reset mid-operation: FIFO contents are discarded, Busy is cleared, and any in-flight output write is dropped (We=0).

Decomposition:
- Shared package regbank_pkg:
  - NREGS=16, XLEN=16, RIDX_W=4.
  - typedef wb_req_t {logic [3:0] rd; logic [15:0] data;}.
  - The same typedef is used for the FIFO entry and the output register.
- One sub-module, wb_fifo: parameterised DEPTH, wb_req_t payload, synchronous push/pop, full/empty, asynchronous active-low reset.
- Arbitration, scoreboard and starvation logic stay in regbank_wb.

Test Plan:
- ALU only: Iss_Valid with Iss_Rd=3. Next cycle Alu_Valid, Rd=3, Data=16'hBEEF.
  -> We=1, Addr_Rd=3, W_Data=BEEF one cycle later. Busy[3] falls at that edge. Err=0.
- Memory vs ALU contention: issue r5 and r6. Same cycle push Mem Rd=5/0x1234 and ALU Rd=6/0x00AA.
  -> r6 is written at N+1, r5 at N+2. FIFO ends empty.
- FIFO full: DEPTH=4. Hold Alu_Valid every cycle and push 4 memory results.
  -> Mem_Ready=0 after the 4th push.
  -> Wb_Stall asserts once STARVE_MAX=3 lost arbitrations are reached. With ALU idle in that cycle, the head pops and Mem_Ready returns to 1.
- r0 writes: ALU Rd=0/0xFFFF and memory Rd=0.
  -> We never asserts. The FIFO entry is popped. Busy stays 0. Err stays 0.
- Scoreboard race: commit to r7 in the same cycle as Iss_Valid for r7.
  -> Busy[7] remains 1. Hazard=1 for Qry_Ra=7. Qry_Ra=0 gives Hazard=0.
- Reset mid-flight: 3 FIFO entries, We=1 pending. Pulse Rst_n low asynchronously between edges.
  -> Outputs are 0 immediately. FIFO is empty and Mem_Ready=1 after release. No write occurs.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared widths and the write-request record used by the register-bank write front end.
package regbank_pkg;

    localparam int NREGS  = 16;
    localparam int XLEN   = 16;
    localparam int RIDX_W = 4;

    typedef struct packed {
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small non-fall-through FIFO holding memory-side write requests until they win the bank port.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_req_t     mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/regbank_wb.sv
// Write-side front end of the 16x16 register bank: merges ALU and buffered memory results
// onto the single bank write port and tracks pending destinations for hazard detection.
module regbank_wb
    import regbank_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Alu_Valid,
    input  logic [RIDX_W-1:0] Alu_Rd,
    input  logic [XLEN-1:0]   Alu_Data,
    input  logic              Mem_Valid,
    input  logic [RIDX_W-1:0] Mem_Rd,
    input  logic [XLEN-1:0]   Mem_Data,
    output logic              Mem_Ready,
    input  logic              Iss_Valid,
    input  logic [RIDX_W-1:0] Iss_Rd,
    input  logic [RIDX_W-1:0] Qry_Ra,
    input  logic [RIDX_W-1:0] Qry_Rb,
    input  logic [RIDX_W-1:0] Qry_Rd,
    output logic              Hazard,
    output logic              Wb_Stall,
    output logic              We,
    output logic [RIDX_W-1:0] Addr_Rd,
    output logic [XLEN-1:0]   W_Data,
    output logic [NREGS-1:0]  Busy,
    output logic              Err
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

    wb_req_t          alu_req;
    wb_req_t          mem_req;
    wb_req_t          head;
    wb_req_t          win_p0;
    wb_req_t          out_p1;
    logic             vld_p1;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             take;
    logic             lose;
    logic [CW-1:0]    starve_cnt;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             iss_viol;
    logic             alu_viol;
    logic             mem_viol;
    logic             stall_viol;

    assign alu_req   = '{rd: Alu_Rd, data: Alu_Data};
    assign mem_req   = '{rd: Mem_Rd, data: Mem_Data};
    assign Mem_Ready = !fifo_full;
    assign push      = Mem_Valid && !fifo_full;
    assign pop       = !Alu_Valid && !fifo_empty;
    assign take      = Alu_Valid || pop;
    assign lose      = Alu_Valid && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (push),
        .pop   (pop),
        .din   (mem_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stage p0: arbitration, the ALU always wins because it cannot be held off.
    assign win_p0 = Alu_Valid ? alu_req : head;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_p1 <= 1'b0;
            out_p1 <= '0;
        end else begin
            vld_p1 <= take && (win_p0.rd != '0);
            if (take) out_p1 <= win_p0;
        end
    end

    // Stage p1: registered bank write port.
    assign We      = vld_p1;
    assign Addr_Rd = out_p1.rd;
    assign W_Data  = out_p1.data;

    // Set beats clear so a reissue to the register being committed stays pending.
    always_comb begin
        busy_d = busy_q;
        if (We) busy_d[Addr_Rd] = 1'b0;
        if (Iss_Valid) busy_d[Iss_Rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign Busy   = busy_q;
    assign Hazard = busy_q[Qry_Ra] | busy_q[Qry_Rb] | busy_q[Qry_Rd];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            starve_cnt <= '0;
            Wb_Stall   <= 1'b0;
        end else begin
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (lose && (starve_cnt != CNT_LAST))
                starve_cnt <= starve_cnt + CW'(1);
            Wb_Stall <= lose && (starve_cnt == CNT_LAST);
        end
    end

    // A reissue is legal when the pending write to that register commits on this same edge.
    assign iss_viol   = Iss_Valid && (Iss_Rd != '0) && busy_q[Iss_Rd]
                        && !(We && (Addr_Rd == Iss_Rd));
    assign alu_viol   = Alu_Valid && (Alu_Rd != '0) && !busy_q[Alu_Rd];
    assign mem_viol   = push && (Mem_Rd != '0) && !busy_q[Mem_Rd];
    assign stall_viol = Alu_Valid && Wb_Stall;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            Err <= 1'b0;
        else if (iss_viol || alu_viol || mem_viol || stall_viol)
            Err <= 1'b1;
    end

endmodule
